// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction-fetch front end.
//
// Issues sequential fetch requests to instruction memory, collects the in-order
// responses into a DEPTH-entry prefetch queue and presents the queue head to
// decode. A redirect flushes the queue, restarts fetch at the (word-aligned)
// target and squashes every response still in flight.
//
// Handshake rule for every channel here: a transfer happens on a rising clk
// edge where valid and ready are both 1. Once a producer raises valid it holds
// valid and its payload stable until that edge. The one exception is the
// memory request, which redirect_valid may withdraw. imem_rsp_valid has no
// ready: it is a one-cycle pulse that must always be accepted.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel (addr = fetch_pc)
//   imem_rsp_valid/data            in-order response pulse and instruction word
//   redirect_valid/pc              one-cycle redirect strobe and target
//   inst_valid/ready/out/pc        queue head toward decode
//   fetch_pc                       next address to request
//   queue_count                    occupied queue entries
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [31:0]             imem_rsp_data,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst_out,
  output logic [XLEN-1:0]         inst_pc,
  output logic [XLEN-1:0]         fetch_pc,
  output logic [$clog2(DEPTH):0]  queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   live;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_aligned;

  // One extra bit so the sum of three counters cannot wrap.
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;

  assign occupancy        = (CW+1)'(live) + (CW+1)'(drop) + (CW+1)'(count);
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit rule: every outstanding request already owns a queue slot, so a
  // response push can never overflow the queue.
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid && ((live != '0) || (drop != '0));
  assign push     = rsp_fire && !redirect_valid && (drop == '0);
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid  = (count != '0);
  assign inst_out    = inst_mem[head];
  assign inst_pc     = pc_mem[head];
  assign queue_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live     <= '0;
      drop     <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      rsp_pc   <= redirect_aligned;
      // Everything still in flight becomes unwanted; a response landing in
      // this very cycle retires one of them immediately.
      drop     <= drop + live - CW'(rsp_fire);
      live     <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) begin
        tail   <= tail + AW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) head <= head + AW'(1);
      if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
      live  <= live + CW'(req_fire) - CW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage carries no reset; entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[tail]   <= rsp_pc;
      inst_mem[tail] <= imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occupancy <= (CW+1)'(DEPTH));
      assert (!inst_valid || (inst_pc[1:0] == 2'b00));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
//
// Inputs are driven on the falling edge, outputs are sampled there as well.
// A small memory model echoes the request address as the instruction word
// after a programmable latency (captured by the DUT lat edges after the
// request edge). A second instance with RESET_PC = FFFF_FFF8 covers PC wrap.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0, DEPTH = 4).
  logic        rst            = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;
  logic [2:0]  queue_count;

  // Wrap instance (RESET_PC = FFFF_FFF8), memory always ready, latency 1.
  logic        rst_2            = 1'b1;
  logic        imem_req_valid_2;
  logic [31:0] imem_req_addr_2;
  logic        imem_rsp_valid_2 = 1'b0;
  logic [31:0] imem_rsp_data_2  = '0;
  logic        inst_valid_2;
  logic        inst_ready_2     = 1'b0;
  logic [31:0] inst_out_2;
  logic [31:0] inst_pc_2;
  logic [31:0] fetch_pc_2;
  logic [2:0]  queue_count_2;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc), .queue_count(queue_count)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_wrap (
    .clk(clk), .rst(rst_2),
    .imem_req_valid(imem_req_valid_2), .imem_req_ready(1'b1),
    .imem_req_addr(imem_req_addr_2),
    .imem_rsp_valid(imem_rsp_valid_2), .imem_rsp_data(imem_rsp_data_2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(inst_valid_2), .inst_ready(inst_ready_2),
    .inst_out(inst_out_2), .inst_pc(inst_pc_2),
    .fetch_pc(fetch_pc_2), .queue_count(queue_count_2)
  );

  // ---------------- memory models ----------------
  int          cyc   = 0;
  int          lat   = 1;
  int          n_acc = 0;
  int          acc_cyc_q [$];
  logic [31:0] acc_addr_q [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      acc_cyc_q.delete();
      acc_addr_q.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      acc_cyc_q.push_back(cyc);
      acc_addr_q.push_back(imem_req_addr);
      n_acc = n_acc + 1;
    end
  end

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (acc_cyc_q.size() > 0 && cyc >= acc_cyc_q[0] + lat - 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = acc_addr_q.pop_front();
      void'(acc_cyc_q.pop_front());
    end
  end

  logic        pend_2 = 1'b0;
  logic [31:0] pend_addr_2 = '0;

  always @(posedge clk) begin
    pend_2      = imem_req_valid_2 && !rst_2;
    pend_addr_2 = imem_req_addr_2;
  end

  always @(negedge clk) begin
    imem_rsp_valid_2 = pend_2;
    imem_rsp_data_2  = pend_addr_2;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_inst(input int budget, input string tag);
    int k = 0;
    while (!inst_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!inst_valid) check(tag, 64'd0, 64'd1);
  endtask

  logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  int base;

  initial begin
    // ---- reset state, then streaming with 1-cycle memory ----
    rst = 1'b1; imem_req_ready = 1'b1; lat = 1; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_count", queue_count, 0);
    rst = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 0);
    @(negedge clk);
    check("lat_one_edge_empty", inst_valid, 0);
    check("fetch_pc_adv", fetch_pc, 4);
    @(negedge clk);
    check("lat_two_edges_valid", inst_valid, 1);
    check("seq_pc_0", inst_pc, 0);
    check("seq_out_0", inst_out, 0);
    inst_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("seq_valid", inst_valid, 1);
      check("seq_pc", inst_pc, 64'(i * 4));
      check("seq_out", inst_out, 64'(i * 4));
    end
    check("seq_count", queue_count, 1);

    // ---- decode stall: credits cap requests at DEPTH ----
    rst = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = n_acc;
    repeat (10) @(negedge clk);
    check("stall_reqs", 64'(n_acc - base), 4);
    check("stall_count", queue_count, 4);
    check("stall_req_valid", imem_req_valid, 0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("pop_head_pc", inst_pc, 4);
    check("pop_frees_credit", imem_req_valid, 1);
    repeat (5) @(negedge clk);
    check("one_more_req", 64'(n_acc - base), 5);
    check("refill_count", queue_count, 4);

    // ---- redirect with two requests in flight, latency 3 ----
    rst = 1'b1; imem_req_ready = 1'b0; lat = 3; inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
    #1;
    check("redir_no_req", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    check("redir_fetch_pc", fetch_pc, 32'h0000_1000);
    check("redir_empty", queue_count, 0);
    wait_inst(20, "redir_timeout");
    check("redir_pc", inst_pc, 32'h0000_1000);
    check("redir_out", inst_out, 32'h0000_1000);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("redir_next_pc", inst_pc, 32'h0000_1004);

    // ---- redirect coincident with a response and a pop ----
    rst = 1'b1; imem_req_ready = 1'b1; lat = 2; inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("coinc_pre_count", queue_count, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; inst_ready = 1'b0;
    check("coinc_empty", queue_count, 0);
    check("coinc_inst_valid", inst_valid, 0);
    check("coinc_fetch_pc", fetch_pc, 32'h0000_2000);
    wait_inst(20, "coinc_timeout");
    check("coinc_pc", inst_pc, 32'h0000_2000);
    check("coinc_out", inst_out, 32'h0000_2000);

    // ---- reset mid-stream ----
    rst = 1'b1; imem_req_ready = 1'b1; lat = 2; inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_pre_count", queue_count, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_count", queue_count, 0);
    check("mid_inst_valid", inst_valid, 0);
    check("mid_fetch_pc", fetch_pc, 0);
    check("mid_req_valid", imem_req_valid, 0);
    rst = 1'b0;
    #1;
    check("mid_credits_clear", imem_req_valid, 1);
    wait_inst(20, "mid_timeout");
    check("mid_restart_pc", inst_pc, 0);

    // ---- PC wrap from RESET_PC = FFFF_FFF8 ----
    @(negedge clk);
    @(negedge clk);
    rst_2 = 1'b0;
    repeat (8) @(negedge clk);
    check("wrap_count", queue_count_2, 4);
    for (int i = 0; i < 4; i++) begin
      check("wrap_pc", inst_pc_2, wrap_exp[i]);
      check("wrap_out", inst_out_2, wrap_exp[i]);
      inst_ready_2 = 1'b1;
      @(negedge clk);
      inst_ready_2 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
